// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: owns HI/LO, runs a one-cycle multiply or a
// DIV_CYCLES-long restoring divide, and requests a pipeline stall while busy.
module ex_mdu #(
   parameter int DATA_W     = 32,
   parameter int DIV_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              flush,
   input  logic              stall_in,
   input  logic [5:0]        funct,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              stall_req,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic [DATA_W-1:0] result
);

   localparam int CNT_W = $clog2(DIV_CYCLES);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [DATA_W-1:0] quo_q, quo_d;   // multiplicand, or dividend shifting into quotient
   logic [DATA_W-1:0] div_q, div_d;   // multiplier, or divisor magnitude
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              signed_q, signed_d;
   logic              neg_quo_q, neg_quo_d;
   logic              neg_rem_q, neg_rem_d;

   logic                is_mul_s, is_div_s, start_s, sdiv_s;
   logic [DATA_W-1:0]   a_abs_s, b_abs_s;
   logic [2*DATA_W-1:0] mul_a_s, mul_b_s, prod_s;
   logic [DATA_W:0]     rem_sh_s, diff_s;
   logic [DATA_W-1:0]   rem_nx_s, quo_nx_s;

   assign is_mul_s = (funct == F_MULT) || (funct == F_MULTU);
   assign is_div_s = (funct == F_DIV)  || (funct == F_DIVU);
   assign start_s  = en && !flush && (state_q == ST_IDLE) && (is_mul_s || is_div_s);
   assign sdiv_s   = (funct == F_DIV);

   assign a_abs_s = (sdiv_s && op_a[DATA_W-1]) ? (~op_a + {{(DATA_W-1){1'b0}}, 1'b1}) : op_a;
   assign b_abs_s = (sdiv_s && op_b[DATA_W-1]) ? (~op_b + {{(DATA_W-1){1'b0}}, 1'b1}) : op_b;

   assign mul_a_s = signed_q ? {{DATA_W{quo_q[DATA_W-1]}}, quo_q} : {{DATA_W{1'b0}}, quo_q};
   assign mul_b_s = signed_q ? {{DATA_W{div_q[DATA_W-1]}}, div_q} : {{DATA_W{1'b0}}, div_q};
   assign prod_s  = mul_a_s * mul_b_s;

   // One restoring step: the partial remainder is always below twice the divisor.
   assign rem_sh_s = {rem_q, quo_q[DATA_W-1]};
   assign diff_s   = rem_sh_s - {1'b0, div_q};
   assign rem_nx_s = diff_s[DATA_W] ? rem_sh_s[DATA_W-1:0] : diff_s[DATA_W-1:0];
   assign quo_nx_s = {quo_q[DATA_W-2:0], ~diff_s[DATA_W]};

   assign stall_req = start_s || (state_q == ST_MUL) || (state_q == ST_DIV);
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign result    = (funct == F_MFHI) ? hi_q : ((funct == F_MFLO) ? lo_q : {DATA_W{1'b0}});

   // Next-state and HI/LO update logic; flush discards any in-flight result.
   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      quo_d     = quo_q;
      div_d     = div_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      signed_d  = signed_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_s && is_mul_s) begin
                  quo_d    = op_a;
                  div_d    = op_b;
                  signed_d = (funct == F_MULT);
                  state_d  = ST_MUL;
               end else if (start_s && (op_b != {DATA_W{1'b0}})) begin
                  quo_d     = a_abs_s;
                  div_d     = b_abs_s;
                  rem_d     = {DATA_W{1'b0}};
                  cnt_d     = {CNT_W{1'b0}};
                  neg_quo_d = sdiv_s && (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
                  neg_rem_d = sdiv_s && op_a[DATA_W-1];
                  state_d   = ST_DIV;
               end else if (start_s) begin
                  state_d = ST_DONE;
               end else if (en && (funct == F_MTHI)) begin
                  hi_d = op_a;
               end else if (en && (funct == F_MTLO)) begin
                  lo_d = op_a;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_MUL: begin
               hi_d    = prod_s[2*DATA_W-1:DATA_W];
               lo_d    = prod_s[DATA_W-1:0];
               state_d = ST_DONE;
            end
            ST_DIV: begin
               rem_d = rem_nx_s;
               quo_d = quo_nx_s;
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                  lo_d    = neg_quo_q ? (~quo_nx_s + {{(DATA_W-1){1'b0}}, 1'b1}) : quo_nx_s;
                  hi_d    = neg_rem_q ? (~rem_nx_s + {{(DATA_W-1){1'b0}}, 1'b1}) : rem_nx_s;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_DIV;
               end
            end
            ST_DONE: begin
               state_d = stall_in ? ST_DONE : ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         hi_q      <= {DATA_W{1'b0}};
         lo_q      <= {DATA_W{1'b0}};
         quo_q     <= {DATA_W{1'b0}};
         div_q     <= {DATA_W{1'b0}};
         rem_q     <= {DATA_W{1'b0}};
         cnt_q     <= {CNT_W{1'b0}};
         signed_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         quo_q     <= quo_d;
         div_q     <= div_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         signed_q  <= signed_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

endmodule
